ftdi_fifo_bridge: RTL and testbench

FTDI_FIFO_BRIDGE -- requirements
Module: ftdi_fifo_bridge

---
 rtl/ftdi_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/ftdi_fifo_bridge.sv | 169 ++++++++++++++++
 tb/tb_ftdi_fifo_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared FSM state encoding and default timing for the FTDI FIFO bridge.
// Pure declarations: no logic, no latency, no flow control.
package ftdi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        WR_SETUP,
        WR_STROBE,
        TURN
    } bridge_state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_RD_PULSE = 4;
    localparam int DEF_WR_PULSE = 4;
    localparam int DEF_TURN_CYC = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head visible while count>0, one-cycle push-to-visible latency.
// Push when full and pop when empty are ignored unless paired with the opposite operation.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A paired push/pop always moves both pointers so occupancy holds steady at the extremes.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    assign pop_data = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// Bridges an FTDI async-FIFO bus to rx/tx valid-ready streams through two FWFT buffers.
// Bus reads stall while rx is full, writes wait for tx data; RXF#/TXE# add two sync cycles.
module ftdi_fifo_bridge
    import ftdi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RD_PULSE = DEF_RD_PULSE,
    parameter int WR_PULSE = DEF_WR_PULSE,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    rxf,
    input  logic                    txe,
    input  logic [DATA_W-1:0]       adbus_in,
    output logic [DATA_W-1:0]       adbus_out,
    output logic                    adbus_tri,
    output logic                    ftdi_rd,
    output logic                    ftdi_wr,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic [$clog2(DEPTH):0]  tx_count
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(max3(RD_PULSE, WR_PULSE, TURN_CYC) + 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

    bridge_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last_wr, last_wr_nxt;
    logic              load_out;
    logic              rxf_meta, rxf_sync, txe_meta, txe_sync;
    logic              rd_ok, wr_ok;
    logic              rx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxf_meta <= 1'b1;
            rxf_sync <= 1'b1;
            txe_meta <= 1'b1;
            txe_sync <= 1'b1;
        end else begin
            rxf_meta <= rxf;
            rxf_sync <= rxf_meta;
            txe_meta <= txe;
            txe_sync <= txe_meta;
        end
    end

    assign rd_ok = en && !rxf_sync && (rx_count < CW'(DEPTH));
    assign wr_ok = en && !txe_sync && (tx_count != '0);

    // last_wr resets high so the first contested grant goes to the read side.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_wr   <= 1'b1;
            adbus_out <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last_wr <= last_wr_nxt;
            if (load_out) begin
                adbus_out <= tx_head;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_wr_nxt = last_wr;
        load_out    = 1'b0;
        rx_push     = 1'b0;
        tx_pop      = 1'b0;
        ftdi_rd     = 1'b1;
        ftdi_wr     = 1'b1;
        adbus_tri   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rd_ok && (!wr_ok || last_wr)) begin
                    state_nxt   = RD_STROBE;
                    last_wr_nxt = 1'b0;
                end else if (wr_ok) begin
                    state_nxt   = WR_SETUP;
                    last_wr_nxt = 1'b1;
                    load_out    = 1'b1;
                end
            end
            RD_STROBE: begin
                ftdi_rd = 1'b0;
                if (cnt == RD_LAST) begin
                    rx_push   = 1'b1;
                    state_nxt = TURN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                adbus_tri = 1'b1;
                state_nxt = WR_STROBE;
                cnt_nxt   = '0;
            end
            WR_STROBE: begin
                adbus_tri = 1'b1;
                ftdi_wr   = 1'b0;
                if (cnt == WR_LAST) begin
                    tx_pop    = 1'b1;
                    state_nxt = TURN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            TURN: begin
                // Keep driving one extra cycle after a write for data hold on the pins.
                adbus_tri = last_wr && (cnt == '0);
                if (cnt == TURN_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_valid = (rx_count != '0);
    assign tx_ready = (tx_count < CW'(DEPTH));

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (adbus_in),
        .pop       (rx_valid && rx_ready),
        .pop_data  (rx_data),
        .count     (rx_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .count     (tx_count)
    );

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Directed bench for ftdi_fifo_bridge: queue-level model of both buffers plus bus-protocol rules.
module tb_ftdi_fifo_bridge;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int RD_PULSE = 4;
    localparam int WR_PULSE = 4;
    localparam int TURN_CYC = 2;
    localparam logic [7:0] G_R = 8'h52;
    localparam logic [7:0] G_W = 8'h57;

    logic clock = 1'b0;
    logic reset, en, rxf, txe, rx_ready, tx_valid;
    logic [DATA_W-1:0] adbus_in, tx_data;
    logic [DATA_W-1:0] adbus_out, rx_data;
    logic adbus_tri, ftdi_rd, ftdi_wr, rx_valid, tx_ready;
    logic [$clog2(DEPTH):0] rx_count, tx_count;

    ftdi_fifo_bridge #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_PULSE(RD_PULSE),
        .WR_PULSE(WR_PULSE), .TURN_CYC(TURN_CYC)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .rxf(rxf), .txe(txe),
        .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_tri(adbus_tri),
        .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Model state: buffer contents and bus-observation history.
    logic [DATA_W-1:0] rxq[$];
    logic [DATA_W-1:0] txq[$];
    logic [7:0]        grants[$];
    logic [DATA_W-1:0] wr_bytes[$];
    logic p_rd = 1'b1, p_wr = 1'b1, p_tri = 1'b0, p_rxpop = 1'b0, p_txpush = 1'b0;
    logic [DATA_W-1:0] p_adin = '0, p_txdat = '0;
    int rd_run = 0, wr_run = 0, idle_run = TURN_CYC, since_wr = 0;
    int n_rd = 0, n_wr = 0, n_rd_done = 0, n_wr_done = 0;

    always @(negedge clock) begin
        if (reset) begin
            rxq.delete();
            txq.delete();
            p_rd = 1'b1; p_wr = 1'b1; p_tri = 1'b0; p_rxpop = 1'b0; p_txpush = 1'b0;
            rd_run = 0; wr_run = 0; idle_run = TURN_CYC; since_wr = 0;
        end else begin
            if (p_rxpop && rxq.size() > 0) void'(rxq.pop_front());
            if (since_wr > 0) since_wr++;
            if (!p_wr && ftdi_wr) begin
                if (txq.size() > 0) void'(txq.pop_front());
                chk("wr_pulse_len", 32'(wr_run), 32'(WR_PULSE));
                wr_run = 0; n_wr_done++; since_wr = 1;
            end
            if (p_txpush) txq.push_back(p_txdat);
            if (!p_rd && ftdi_rd) begin
                rxq.push_back(p_adin);
                chk("rd_pulse_len", 32'(rd_run), 32'(RD_PULSE));
                rd_run = 0; n_rd_done++;
            end
            if (p_rd && !ftdi_rd) begin
                n_rd++; grants.push_back(G_R);
                chk("gap_before_rd", 32'(idle_run >= TURN_CYC), 32'd1);
            end
            if (p_wr && !ftdi_wr) begin
                n_wr++; grants.push_back(G_W); wr_bytes.push_back(adbus_out);
                chk("wr_setup_tri", 32'(p_tri), 32'd1);
                chk("gap_before_wr", 32'(idle_run >= TURN_CYC), 32'd1);
            end
            if (!ftdi_rd) rd_run++;
            if (!ftdi_wr) wr_run++;
            idle_run = (ftdi_rd && ftdi_wr) ? idle_run + 1 : 0;
            if (since_wr == 1) chk("tri_hold_after_wr", 32'(adbus_tri), 32'd1);
            if (since_wr == 2) begin
                chk("tri_release_after_wr", 32'(adbus_tri), 32'd0);
                since_wr = 0;
            end
            chk("rx_count", 32'(rx_count), 32'(rxq.size()));
            chk("tx_count", 32'(tx_count), 32'(txq.size()));
            chk("rx_valid", 32'(rx_valid), 32'(rxq.size() > 0));
            chk("tx_ready", 32'(tx_ready), 32'(txq.size() < DEPTH));
            if (rxq.size() > 0) chk("rx_data", 32'(rx_data), 32'(rxq[0]));
            chk("tri_with_rd", 32'(adbus_tri && !ftdi_rd), 32'd0);
            if (!ftdi_wr) begin
                chk("wr_tri", 32'(adbus_tri), 32'd1);
                chk("wr_has_data", 32'(txq.size() > 0), 32'd1);
                if (txq.size() > 0) chk("wr_data", 32'(adbus_out), 32'(txq[0]));
            end
            p_rd = ftdi_rd; p_wr = ftdi_wr; p_tri = adbus_tri; p_adin = adbus_in;
            p_rxpop = rx_valid && rx_ready; p_txpush = tx_valid && tx_ready; p_txdat = tx_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic hit;
        reset = 1'b1; en = 1'b0; rxf = 1'b1; txe = 1'b1; adbus_in = '0;
        rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        chk("reset_rd", 32'(ftdi_rd), 32'd1);
        chk("reset_wr", 32'(ftdi_wr), 32'd1);
        chk("reset_tri", 32'(adbus_tri), 32'd0);
        chk("reset_out", 32'(adbus_out), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        chk("reset_counts", 32'({rx_count, tx_count}), 32'd0);

        // Two bytes read from the FTDI side.
        en = 1'b1; adbus_in = 8'h41; rxf = 1'b0;
        for (int t = 0; t < 200 && n_rd_done < 1; t++) step(1);
        chk("t1_first_read", 32'(n_rd_done), 32'd1);
        adbus_in = 8'h42;
        for (int t = 0; t < 200 && n_rd < 2; t++) step(1);
        rxf = 1'b1;
        for (int t = 0; t < 200 && n_rd_done < 2; t++) step(1);
        step(10);
        chk("t1_reads", 32'(n_rd), 32'd2);
        chk("t1_rx_count", 32'(rx_count), 32'd2);
        chk("t1_byte0", 32'(rx_data), 32'h41);
        rx_ready = 1'b1;
        step(1);
        chk("t1_byte1", 32'(rx_data), 32'h42);
        step(1);
        rx_ready = 1'b0;
        chk("t1_drained", 32'(rx_valid), 32'd0);

        // Single write of 0xA5.
        txe = 1'b0;
        step(3);
        wr_bytes.delete();
        tx_data = 8'hA5; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        for (int t = 0; t < 200 && n_wr < 1; t++) step(1);
        txe = 1'b1;
        for (int t = 0; t < 200 && n_wr_done < 1; t++) step(1);
        step(4);
        chk("t2_writes", 32'(n_wr), 32'd1);
        chk("t2_logged", 32'(wr_bytes.size()), 32'd1);
        if (wr_bytes.size() > 0) chk("t2_byte", 32'(wr_bytes[0]), 32'hA5);
        chk("t2_tx_empty", 32'(tx_count), 32'd0);

        // Both sides eligible: grants alternate starting with a read.
        en = 1'b0; rxf = 1'b0; txe = 1'b0; adbus_in = 8'h60; rx_ready = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h10;
        step(1);
        tx_data = 8'h11;
        step(1);
        tx_valid = 1'b0;
        grants.delete(); wr_bytes.delete();
        step(2);
        en = 1'b1;
        for (int t = 0; t < 300 && grants.size() < 4; t++) step(1);
        en = 1'b0; rxf = 1'b1; txe = 1'b1;
        step(20);
        chk("t3_grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            chk("t3_grant0", 32'(grants[0]), 32'(G_R));
            chk("t3_grant1", 32'(grants[1]), 32'(G_W));
            chk("t3_grant2", 32'(grants[2]), 32'(G_R));
            chk("t3_grant3", 32'(grants[3]), 32'(G_W));
        end
        chk("t3_wr_count", 32'(wr_bytes.size()), 32'd2);
        if (wr_bytes.size() == 2) begin
            chk("t3_wr0", 32'(wr_bytes[0]), 32'h10);
            chk("t3_wr1", 32'(wr_bytes[1]), 32'h11);
        end
        chk("t3_tx_empty", 32'(tx_count), 32'd0);

        // en low blocks new transactions; raising it starts a read promptly.
        rxf = 1'b0; adbus_in = 8'h3C;
        base = n_rd + n_wr;
        step(20);
        chk("t5_no_strobe", 32'(n_rd + n_wr), 32'(base));
        en = 1'b1;
        hit = 1'b0;
        for (int t = 0; t < 2 && !hit; t++) begin
            step(1);
            if (!ftdi_rd) hit = 1'b1;
        end
        chk("t5_rd_within_2", 32'(hit), 32'd1);
        rxf = 1'b1; en = 1'b0;
        step(15);
        chk("t5_single_read", 32'(n_rd + n_wr), 32'(base + 1));

        // Fill the rx buffer with the consumer stalled.
        rx_ready = 1'b0; adbus_in = 8'h77; rxf = 1'b0; en = 1'b1;
        base = n_rd;
        for (int t = 0; t < 400 && rx_count < 5'd16; t++) step(1);
        step(30);
        chk("t4_reads_to_full", 32'(n_rd - base), 32'd16);
        chk("t4_full_count", 32'(rx_count), 32'd16);
        chk("t4_bus_idle", 32'(ftdi_rd), 32'd1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(30);
        chk("t4_one_more", 32'(n_rd - base), 32'd17);
        chk("t4_refull", 32'(rx_count), 32'd16);
        rxf = 1'b1;
        step(3);
        rx_ready = 1'b1;
        step(20);
        rx_ready = 1'b0;
        chk("t4_drained", 32'(rx_count), 32'd0);

        // Reset during a write strobe releases the bus at once.
        txe = 1'b0; tx_data = 8'h5A; tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            step(1);
            if (!ftdi_wr) hit = 1'b1;
        end
        chk("t6_wr_started", 32'(hit), 32'd1);
        step(1);
        chk("t6_wr_low_2nd", 32'(ftdi_wr), 32'd0);
        reset = 1'b1;
        #1;
        chk("t6_wr_released", 32'(ftdi_wr), 32'd1);
        chk("t6_tri_released", 32'(adbus_tri), 32'd0);
        chk("t6_tx_count", 32'(tx_count), 32'd0);
        step(2);
        en = 1'b0; txe = 1'b1;
        reset = 1'b0;
        step(3);
        chk("t6_post_tx_ready", 32'(tx_ready), 32'd1);
        chk("t6_post_wr", 32'(ftdi_wr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
